// File: rtl/digit_code_tx_pkg.sv
// rtl/digit_code_tx_pkg.sv - shared types, constants and codeword encoder for the digit-code transmitter
package digit_code_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int FRAME_BITS = 7;
    localparam int DATA_BITS  = 5;
    localparam int MAX_DIGIT  = 9;

    // Codeword order is {c1, c2, c3, c4, c6}; c6 makes the five bits even parity
    function automatic logic [DATA_BITS-1:0] encode(input logic [3:0] digit);
        return {digit, ^digit};
    endfunction

endpackage

// File: rtl/digit_code_tx_if.sv
// rtl/digit_code_tx_if.sv - digit valid/ready handshake bundle
interface digit_code_tx_if;
    logic [3:0] digit;
    logic       valid;
    logic       ready;

    modport master (output digit, output valid, input  ready);
    modport slave  (input  digit, input  valid, output ready);
endinterface

// File: rtl/digit_code_tx_bit_timer.sv
// rtl/digit_code_tx_bit_timer.sv - bit-period counter with end-of-period tick
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    // Count 0..CLKS_PER_BIT-1 and wrap; held at 0 while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/digit_code_tx.sv
// rtl/digit_code_tx.sv - digit to parity codeword, parallel hold and framed serial transmit
module digit_code_tx
    import digit_code_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    digit_code_tx_if.slave  bus,
    output logic            err,
    output logic            busy,
    output logic            tx,
    output logic            c1,
    output logic            c2,
    output logic            c3,
    output logic            c4,
    output logic            c6
);
    state_e                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   code_q, code_d;
    logic                   tx_q, tx_d;
    logic                   err_q, err_d;
    logic                   tick;
    logic                   ready;
    logic                   accept;
    logic                   legal;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    // The last cycle of the stop bit also accepts, so a held valid starts
    // the next frame exactly one frame length after the previous accept
    assign ready  = (state_q == IDLE) || ((state_q == STOP) && tick);
    assign accept = bus.valid && ready;
    assign legal  = (bus.digit <= 4'(MAX_DIGIT));

    assign bus.ready = ready;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign err       = err_q;
    assign {c1, c2, c3, c4, c6} = code_q;

    // Next-state: framing sequence and codeword capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        tx_d    = tx_q;
        err_d   = accept && !legal;
        unique case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    state_d = START;
                    code_d  = encode(bus.digit);
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = code_q[DATA_BITS-1];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = code_q[3'd3 - idx_q];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (accept && legal) begin
                        state_d = START;
                        code_d  = encode(bus.digit);
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            code_q  <= '0;
            tx_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_digit_code_tx.sv
// tb/tb_digit_code_tx.sv - directed self-checking bench for digit_code_tx
module tb_digit_code_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic err, busy, tx, c1, c2, c3, c4, c6;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    digit_code_tx_if bus ();

    digit_code_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .err   (err),
        .busy  (busy),
        .tx    (tx),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c6    (c6)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] code();
        return {c1, c2, c3, c4, c6};
    endfunction

    // Called one sample after the accept edge; leaves us one sample after edge N+28
    task automatic check_frame(input string tag, input logic [4:0] exp);
        int  b;
        logic e;
        for (int k = 0; k < 7 * CPB; k++) begin
            b = k / CPB;
            if (b == 0)      e = 1'b0;
            else if (b == 6) e = 1'b1;
            else             e = exp[5 - b];
            check({tag, "_tx"}, 8'(tx), 8'(e));
            check({tag, "_busy"}, 8'(busy), 8'd1);
            check({tag, "_ready"}, 8'(bus.ready), (k == 7 * CPB - 1) ? 8'd1 : 8'd0);
            if (k == 0 || k == 7 * CPB - 1)
                check({tag, "_code"}, 8'(code()), 8'(exp));
            step();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.digit = 4'd0;
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            check("idle_ready", 8'(bus.ready), 8'd1);
            check("idle_tx", 8'(tx), 8'd1);
            check("idle_busy", 8'(busy), 8'd0);
            check("idle_err", 8'(err), 8'd0);
            check("idle_code", 8'(code()), 8'd0);
            step();
        end

        // Digit 5: single-cycle offer
        bus.digit = 4'd5; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        check_frame("d5", 5'b01010);
        check("d5_end_ready", 8'(bus.ready), 8'd1);
        check("d5_end_busy", 8'(busy), 8'd0);
        check("d5_end_tx", 8'(tx), 8'd1);
        check("d5_hold_code", 8'(code()), 8'h0a);

        // Digit 7: parity bit set
        bus.digit = 4'd7; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        check_frame("d7", 5'b01111);

        // Digit 12: illegal
        bus.digit = 4'd12; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        check("d12_err", 8'(err), 8'd1);
        check("d12_ready", 8'(bus.ready), 8'd1);
        check("d12_tx", 8'(tx), 8'd1);
        check("d12_busy", 8'(busy), 8'd0);
        check("d12_code", 8'(code()), 8'h0f);
        step();
        check("d12_err_off", 8'(err), 8'd0);
        check("d12_tx2", 8'(tx), 8'd1);
        check("d12_code2", 8'(code()), 8'h0f);
        step();

        // Valid held: 9 then 3 changed mid-frame
        bus.digit = 4'd9; bus.valid = 1'b1;
        step();
        bus.digit = 4'd3;
        check_frame("d9", 5'b10010);
        bus.valid = 1'b0;
        check_frame("d3", 5'b00110);

        // Reset during the third data bit
        bus.digit = 4'd6; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("pre_rst_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tx", 8'(tx), 8'd1);
        check("rst_ready", 8'(bus.ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_code", 8'(code()), 8'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_tx", 8'(tx), 8'd1);
        check("post_rst_busy", 8'(busy), 8'd0);
        bus.digit = 4'd0; bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        check_frame("d0", 5'b00000);
        check("d0_end_busy", 8'(busy), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
